// File: rtl/convolution_scheduler.sv
// convolution_scheduler
//
// Sequences the per-sample work of the audio convolution engine. An accepted
// audio_trigger first performs a read-modify-write of the history line that
// holds the current write position. It then streams every impulse-response
// line, together with its matching history line, to the MAC datapath. When
// the accumulation is finished it pulses result_ready.
//
// Parameters:
//   IMPULSE_LINES  IR length in 1024-bit lines (64 x 16-bit samples per line)
//   READ_LATENCY   BRAM read latency in cycles (>= 1)
//
// Ports:
//   audio_clk                   sole clock, rising edge
//   rst_n_in                    synchronous active-low reset
//   audio_trigger               one-cycle pulse, new sample available
//   impulse_in_memory_complete  IR loaded; triggers are ignored while low,
//                               and falling mid-operation aborts the sample
//   busy                        high in every state except IDLE
//   hist_read_addr              history RAM read line address
//   hist_write_addr             history RAM write line address
//   hist_write_enable           history RAM write strobe
//   hist_lane                   lane the datapath replaces with audio_in
//   ir_read_addr                IR RAM read line address
//   mac_clear                   zeroes the accumulator
//   mac_valid                   RAM data pair valid at the MAC this cycle
//   mac_last                    qualifies the final mac_valid
//   result_ready                accumulator holds the finished sample
//   buffer_index                current write position in samples
//   overrun                     sticky: a trigger arrived while busy
//   overrun_count               (CONV_SCHED_STATS_EN only) saturating count
//                               of dropped triggers
//
// Optional feature macro: CONV_SCHED_STATS_EN
module convolution_scheduler #(
    parameter int IMPULSE_LINES = 750,
    parameter int READ_LATENCY  = 2
) (
    input  logic        audio_clk,
    input  logic        rst_n_in,
    input  logic        audio_trigger,
    input  logic        impulse_in_memory_complete,
    output logic        busy,
    output logic [15:0] hist_read_addr,
    output logic [15:0] hist_write_addr,
    output logic        hist_write_enable,
    output logic [5:0]  hist_lane,
    output logic [15:0] ir_read_addr,
    output logic        mac_clear,
    output logic        mac_valid,
    output logic        mac_last,
    output logic        result_ready,
    output logic [15:0] buffer_index,
    output logic        overrun
`ifdef CONV_SCHED_STATS_EN
    ,
    output logic [15:0] overrun_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        RMW_READ,
        RMW_WRITE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [15:0] LAST_LINE   = 16'(IMPULSE_LINES - 1);
    localparam logic [15:0] LAST_LAT    = 16'(READ_LATENCY - 1);
    localparam logic [15:0] LAST_SAMPLE = 16'(IMPULSE_LINES * 64 - 1);

    state_t                  state;
    logic [15:0]             lat_cnt;
    logic [15:0]             k;
    logic [READ_LATENCY-1:0] valid_sr;
    logic [READ_LATENCY-1:0] last_sr;
    logic [15:0]             head;

    // The history line currently being written is the newest one; the
    // convolution walks backwards in time from it.
    assign head = {6'b0, buffer_index[15:6]};

    // The MAC qualifiers are the ISSUE-cycle flags delayed to line up with
    // the RAM read data.
    assign mac_valid = valid_sr[READ_LATENCY-1];
    assign mac_last  = last_sr[READ_LATENCY-1];

    always_ff @(posedge audio_clk) begin
        if (!rst_n_in) begin
            state             <= IDLE;
            lat_cnt           <= '0;
            k                 <= '0;
            valid_sr          <= '0;
            last_sr           <= '0;
            busy              <= 1'b0;
            hist_read_addr    <= '0;
            hist_write_addr   <= '0;
            hist_write_enable <= 1'b0;
            hist_lane         <= '0;
            ir_read_addr      <= '0;
            mac_clear         <= 1'b0;
            result_ready      <= 1'b0;
            buffer_index      <= '0;
            overrun           <= 1'b0;
`ifdef CONV_SCHED_STATS_EN
            overrun_count     <= '0;
`endif
        end else begin
            hist_write_enable <= 1'b0;
            mac_clear         <= 1'b0;
            result_ready      <= 1'b0;

            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                valid_sr[i] <= valid_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
            valid_sr[0] <= (state == ISSUE);
            last_sr[0]  <= (state == ISSUE) && (k == LAST_LINE);

            // A trigger while busy is dropped; the sample in flight is not
            // disturbed.
            if (audio_trigger && busy) begin
                overrun <= 1'b1;
`ifdef CONV_SCHED_STATS_EN
                if (overrun_count != 16'hFFFF) begin
                    overrun_count <= overrun_count + 16'd1;
                end
`endif
            end

            // Losing the IR mid-sample abandons the work; any history write
            // already issued stays in the RAM.
            if (state != IDLE && !impulse_in_memory_complete) begin
                state    <= IDLE;
                busy     <= 1'b0;
                valid_sr <= '0;
                last_sr  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (audio_trigger && impulse_in_memory_complete) begin
                            state          <= RMW_READ;
                            busy           <= 1'b1;
                            lat_cnt        <= '0;
                            hist_read_addr <= head;
                        end
                    end
                    RMW_READ: begin
                        if (lat_cnt == LAST_LAT) begin
                            state             <= RMW_WRITE;
                            hist_write_enable <= 1'b1;
                            hist_write_addr   <= head;
                            hist_lane         <= buffer_index[5:0];
                            mac_clear         <= 1'b1;
                        end else begin
                            lat_cnt <= lat_cnt + 16'd1;
                        end
                    end
                    RMW_WRITE: begin
                        state          <= ISSUE;
                        k              <= '0;
                        ir_read_addr   <= '0;
                        hist_read_addr <= head;
                    end
                    ISSUE: begin
                        if (k == LAST_LINE) begin
                            state   <= DRAIN;
                            lat_cnt <= '0;
                        end else begin
                            k            <= k + 16'd1;
                            ir_read_addr <= k + 16'd1;
                            // (head - k) mod IMPULSE_LINES: step back one line,
                            // adding IMPULSE_LINES back in when it would go
                            // below zero.
                            if (hist_read_addr == 16'd0) begin
                                hist_read_addr <= LAST_LINE;
                            end else begin
                                hist_read_addr <= hist_read_addr - 16'd1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (lat_cnt == LAST_LAT) begin
                            state        <= DONE;
                            result_ready <= 1'b1;
                        end else begin
                            lat_cnt <= lat_cnt + 16'd1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (buffer_index == LAST_SAMPLE) begin
                            buffer_index <= '0;
                        end else begin
                            buffer_index <= buffer_index + 16'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_convolution_scheduler.sv
// Self-checking bench for convolution_scheduler with IMPULSE_LINES=4 and
// READ_LATENCY=2. Each loop iteration of the vector table is one clock cycle
// of a complete sample, counted from the trigger cycle T.
module tb_convolution_scheduler;

    logic        audio_clk = 1'b0;
    logic        rst_n_in;
    logic        audio_trigger;
    logic        impulse_in_memory_complete;
    logic        busy;
    logic [15:0] hist_read_addr;
    logic [15:0] hist_write_addr;
    logic        hist_write_enable;
    logic [5:0]  hist_lane;
    logic [15:0] ir_read_addr;
    logic        mac_clear;
    logic        mac_valid;
    logic        mac_last;
    logic        result_ready;
    logic [15:0] buffer_index;
    logic        overrun;
`ifdef CONV_SCHED_STATS_EN
    logic [15:0] overrun_count;
`endif

    int errors = 0;
    int checks = 0;

    convolution_scheduler #(
        .IMPULSE_LINES(4),
        .READ_LATENCY (2)
    ) dut (
        .audio_clk                 (audio_clk),
        .rst_n_in                  (rst_n_in),
        .audio_trigger             (audio_trigger),
        .impulse_in_memory_complete(impulse_in_memory_complete),
        .busy                      (busy),
        .hist_read_addr            (hist_read_addr),
        .hist_write_addr           (hist_write_addr),
        .hist_write_enable         (hist_write_enable),
        .hist_lane                 (hist_lane),
        .ir_read_addr              (ir_read_addr),
        .mac_clear                 (mac_clear),
        .mac_valid                 (mac_valid),
        .mac_last                  (mac_last),
        .result_ready              (result_ready),
        .buffer_index              (buffer_index),
        .overrun                   (overrun)
`ifdef CONV_SCHED_STATS_EN
        ,
        .overrun_count             (overrun_count)
`endif
    );

    always #5 audio_clk = ~audio_clk;

    typedef struct {
        logic        trig;
        logic        busy;
        logic        we;
        logic        clr;
        logic        valid;
        logic        last;
        logic        ready;
        logic        chk_addr;
        logic [15:0] ir;
        logic [15:0] hra;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic trig, input logic bsy, input logic we,
                                input logic clr, input logic vld, input logic lst,
                                input logic rdy, input logic chk,
                                input logic [15:0] ir, input logic [15:0] hra);
        vec_t v;
        v.trig = trig; v.busy = bsy; v.we = we; v.clr = clr; v.valid = vld;
        v.last = lst; v.ready = rdy; v.chk_addr = chk; v.ir = ir; v.hra = hra;
        return v;
    endfunction

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge audio_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!result_ready && n < 40) begin
            tick();
            n++;
        end
        if (!result_ready) checkOutput("ready_timeout", 32'(result_ready), 32'd1);
    endtask

    // One full sample without detailed checks; ends in the IDLE cycle after DONE.
    task automatic applyStimulus();
        audio_trigger = 1'b1;
        tick();
        audio_trigger = 1'b0;
        wait_ready();
        tick();
    endtask

    // One sample checking the write line/lane and the ISSUE address streams.
    // seq[k] is the expected hist_read_addr for line k.
    task automatic run_checked(input logic [15:0] head, input logic [5:0] lane,
                               input logic [3:0][15:0] seq, input logic [15:0] exp_next);
        audio_trigger = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            audio_trigger = 1'b0;
            if (i == 3) begin
                checkOutput("rmw_we", 32'(hist_write_enable), 32'd1);
                checkOutput("rmw_waddr", 32'(hist_write_addr), 32'(head));
                checkOutput("rmw_lane", 32'(hist_lane), 32'(lane));
            end
            if (i >= 4 && i <= 7) begin
                checkOutput($sformatf("issue_hra_k%0d", i - 4), 32'(hist_read_addr), 32'(seq[i-4]));
                checkOutput($sformatf("issue_ir_k%0d", i - 4), 32'(ir_read_addr), i - 4);
            end
            if (i == 10) checkOutput("ready_t10", 32'(result_ready), 32'd1);
            if (i == 11) begin
                checkOutput("busy_t11", 32'(busy), 32'd0);
                checkOutput("buffer_next", 32'(buffer_index), 32'(exp_next));
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vcount;
        logic seen_ready;

        // Rows: trig busy we clr valid last ready chk ir hra
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd3);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 16'd2);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 16'd1);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd1);
        tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 16'd1);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3, 16'd1);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd1);

        rst_n_in = 1'b0;
        audio_trigger = 1'b0;
        impulse_in_memory_complete = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_buffer", 32'(buffer_index), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_ready", 32'(result_ready), 32'd0);
        checkOutput("rst_valid", 32'(mac_valid), 32'd0);
        checkOutput("rst_hra", 32'(hist_read_addr), 32'd0);
        rst_n_in = 1'b1;
        tick();

        // Trigger ignored while the IR is not loaded.
        audio_trigger = 1'b1;
        tick();
        audio_trigger = 1'b0;
        checkOutput("nocomp_busy", 32'(busy), 32'd0);
        checkOutput("nocomp_overrun", 32'(overrun), 32'd0);
        tick();
        checkOutput("nocomp_busy2", 32'(busy), 32'd0);
        checkOutput("nocomp_buffer", 32'(buffer_index), 32'd0);

        // First full sample, cycle by cycle from the table.
        impulse_in_memory_complete = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            audio_trigger = tbl[i].trig;
            checkOutput($sformatf("busy@T+%0d", i), 32'(busy), 32'(tbl[i].busy));
            checkOutput($sformatf("we@T+%0d", i), 32'(hist_write_enable), 32'(tbl[i].we));
            checkOutput($sformatf("clr@T+%0d", i), 32'(mac_clear), 32'(tbl[i].clr));
            checkOutput($sformatf("valid@T+%0d", i), 32'(mac_valid), 32'(tbl[i].valid));
            checkOutput($sformatf("last@T+%0d", i), 32'(mac_last), 32'(tbl[i].last));
            checkOutput($sformatf("ready@T+%0d", i), 32'(result_ready), 32'(tbl[i].ready));
            if (tbl[i].chk_addr) begin
                checkOutput($sformatf("ir@T+%0d", i), 32'(ir_read_addr), 32'(tbl[i].ir));
                checkOutput($sformatf("hra@T+%0d", i), 32'(hist_read_addr), 32'(tbl[i].hra));
            end
            if (i == 3) begin
                checkOutput("waddr@T+3", 32'(hist_write_addr), 32'd0);
                checkOutput("lane@T+3", 32'(hist_lane), 32'd0);
            end
            tick();
        end
        checkOutput("buffer_after_first", 32'(buffer_index), 32'd1);

        // Advance to buffer_index 64, then walk history lines 1,0,3,2.
        for (int n = 0; n < 63; n++) applyStimulus();
        checkOutput("buffer_64", 32'(buffer_index), 32'd64);
        run_checked(16'd1, 6'd0, {16'd2, 16'd3, 16'd0, 16'd1}, 16'd65);

        // Advance to the last sample position and check the wrap.
        for (int n = 0; n < 190; n++) applyStimulus();
        checkOutput("buffer_255", 32'(buffer_index), 32'd255);
        run_checked(16'd3, 6'd63, {16'd0, 16'd1, 16'd2, 16'd3}, 16'd0);
        checkOutput("overrun_still_clear", 32'(overrun), 32'd0);

        // Abort: IR loaded flag drops during T+5.
        vcount = 0;
        seen_ready = 1'b0;
        audio_trigger = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            audio_trigger = 1'b0;
            if (i == 5) impulse_in_memory_complete = 1'b0;
            if (i == 8) impulse_in_memory_complete = 1'b1;
            if (mac_valid) vcount++;
            if (result_ready) seen_ready = 1'b1;
            if (i == 7) checkOutput("abort_busy_t7", 32'(busy), 32'd0);
        end
        checkOutput("abort_valid_count", vcount, 0);
        checkOutput("abort_no_ready", 32'(seen_ready), 32'd0);
        checkOutput("abort_buffer", 32'(buffer_index), 32'd0);
        checkOutput("abort_overrun", 32'(overrun), 32'd0);

        // Overrun: extra triggers at T+5 and T+10 (DONE) are both dropped.
        audio_trigger = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            audio_trigger = (i == 5 || i == 10);
            if (i == 5) checkOutput("ovr_clear_t5", 32'(overrun), 32'd0);
            if (i == 6) checkOutput("ovr_set_t6", 32'(overrun), 32'd1);
            if (i == 10) checkOutput("ovr_ready_t10", 32'(result_ready), 32'd1);
            if (i == 11) begin
                checkOutput("ovr_busy_t11", 32'(busy), 32'd0);
                checkOutput("ovr_ready_t11", 32'(result_ready), 32'd0);
                checkOutput("ovr_buffer", 32'(buffer_index), 32'd1);
                checkOutput("ovr_sticky", 32'(overrun), 32'd1);
`ifdef CONV_SCHED_STATS_EN
                checkOutput("ovr_count", 32'(overrun_count), 32'd2);
`endif
            end
        end
        audio_trigger = 1'b0;
        tick();
        checkOutput("ovr_no_restart", 32'(busy), 32'd0);

        // Reset in the middle of ISSUE clears everything on the next cycle.
        audio_trigger = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            audio_trigger = 1'b0;
        end
        checkOutput("midrst_valid_before", 32'(mac_valid), 32'd1);
        rst_n_in = 1'b0;
        tick();
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_valid", 32'(mac_valid), 32'd0);
        checkOutput("midrst_ir", 32'(ir_read_addr), 32'd0);
        checkOutput("midrst_hra", 32'(hist_read_addr), 32'd0);
        checkOutput("midrst_waddr", 32'(hist_write_addr), 32'd0);
        checkOutput("midrst_buffer", 32'(buffer_index), 32'd0);
        checkOutput("midrst_overrun", 32'(overrun), 32'd0);
        rst_n_in = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
